// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues sequential fetches to a 1-cycle synchronous
// instruction memory and buffers responses in a small FIFO toward decode.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  logic [31:0]     fetch_pc_q;
  logic [31:0]     inflight_pc_q;
  logic            inflight_q;
  logic [31:0]     inst_q [FIFO_DEPTH];
  logic [31:0]     pc_q   [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] occupancy;
  logic            pop, push, issue;

  assign pop  = if_valid_o && if_ready_i;
  assign push = inflight_q && !redirect_valid_i;

  // Reserve a slot for every outstanding response so a push can never find the FIFO full.
  assign occupancy = count_q + CntW'(inflight_q) - CntW'(pop);
  assign issue     = !redirect_valid_i && (occupancy < DepthC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else if (redirect_valid_i) begin
      fetch_pc_q <= redirect_pc_i & 32'hFFFF_FFFC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (issue) begin
        fetch_pc_q    <= fetch_pc_q + 32'd4;
        inflight_pc_q <= fetch_pc_q;
      end
      inflight_q <= issue;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      inst_q[wr_ptr_q] <= imem_inst_i;
      pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign imem_addr_o = fetch_pc_q;
  assign if_valid_o  = (count_q != '0);
  assign if_inst_o   = inst_q[rd_ptr_q];
  assign if_pc_o     = pc_q[rd_ptr_q];

  overflow_chk: assert property (@(posedge clk_i) disable iff (rst_i)
                                 !(push && !pop && (count_q == DepthC)));

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 2: instruction buffer entries; legal values 2 or 4.
REQ-003 clk  input  1  core clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  XLEN (32)  byte address to instruction memory.
REQ-006 imem_inst  input  ILEN (32)  instruction data; valid on the cycle after imem_addr is presented (1-cycle synchronous read, no enable).
REQ-007 redirect_valid  input  1  pulse; discards fetch state and restarts at redirect_pc.
REQ-008 redirect_pc  input  32  new fetch address.
REQ-009 if_valid  output  1  if_inst/if_pc hold a valid instruction.
REQ-010 if_ready  input  1  decode accepts the instruction this cycle.
REQ-011 if_inst  output  32  instruction at head of buffer.
REQ-012 if_pc  output  32  byte address of if_inst.

Function
REQ-013 imem_addr SHALL equal the fetch_pc register directly, with no combinational path from any input.
REQ-014 Issue condition: issue = !redirect_valid && (count + inflight - pop) < FIFO_DEPTH, where pop = if_valid && if_ready.
REQ-015 On issue, fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000), inflight <= 1, and inflight_pc <= fetch_pc.
REQ-016 On a non-issue cycle without redirect, fetch_pc SHALL hold and inflight <= 0.
REQ-017 When inflight=1 and no redirect occurs this cycle, {imem_inst, inflight_pc} SHALL be pushed into the FIFO at that edge.
REQ-018 Push and pop in the same cycle are legal: count is unchanged, and entry order is preserved.
REQ-019 The FIFO SHALL never overflow; overflow is prevented by REQ-014. A push when full is a design error and SHALL be flagged by an assertion.
REQ-020 if_valid = (count != 0); if_inst/if_pc come from the head entry and SHALL remain stable while if_valid && !if_ready.
REQ-021 Redirect, which has priority over all other events: FIFO cleared (count <= 0), the in-flight response discarded (inflight <= 0, no push), and fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-022 A pop in the redirect cycle SHALL be consumed normally by decode; the controller ignores it.
REQ-023 The first issue after a redirect occurs on the following cycle, giving if_valid a minimum 2-cycle bubble (redirect edge -> issue -> push).
REQ-024 Steady state with if_ready=1 continuously: one instruction per cycle, sequential PCs, no bubbles.
REQ-025 Back-to-back redirects: only the last one takes effect; no stale instruction SHALL ever appear on if_valid.
REQ-026 Addresses beyond the memory size SHALL be passed through unmodified; address decoding belongs to the memory.

Reset
REQ-027 While rst=1: fetch_pc <= RESET_PC, inflight <= 0, FIFO count <= 0, and if_valid = 0 by the next edge.
REQ-028 rst SHALL override redirect_valid and if_ready; FIFO contents need not be cleared, only pointers and count.
REQ-029 The first issue occurs on the first cycle with rst=0 (imem_addr = RESET_PC), and if_valid rises 2 cycles after rst deasserts.
REQ-030 Reset asserted mid-stream SHALL drop all buffered and in-flight instructions with no push on the reset edge.

Verification
REQ-031 Reset release with if_ready=1 and memory word n = n -> if_pc sequence 0,4,8,... with if_inst = 0,1,2,..., and if_valid=1 every cycle from cycle 2 onward.
REQ-032 Hold if_ready=0 for 5 cycles after the first valid -> at most FIFO_DEPTH entries buffered, imem_addr stalls at 8 (depth 2), if_pc=0 stable; on release, PCs 0,4,8 in order with no loss or duplication.
REQ-033 Redirect to 32'h0000_0043 while inflight=1 and the FIFO is full -> the next if_valid carries if_pc=32'h0000_0040; nothing from the old stream appears.
REQ-034 Redirect on two consecutive cycles (0x20, then 0x80) -> the first valid after them has if_pc=0x80.
REQ-035 Redirect to 32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-036 Random if_ready toggling plus random redirects over 10k cycles; a scoreboard checks every accepted if_pc equals the expected sequential/redirect PC and if_inst = mem[if_pc[7:2]], and the overflow assertion never fires.
